tpu_seq_ctrl: RTL and testbench
===============================

# tpu_seq_ctrl

Parametrised burst instruction sequencer for the systolic-array TPU. It accepts one instruction per valid/ready handshake from an instruction queue. Each instruction is executed as a burst of LEN+1 beats, and the unified-buffer/weight-buffer addresses auto-increment per beat. For every beat it drives the buffer, FIFO, MMU, accumulator and AXI-master strobes. It sits between the host instruction queue and the datapath.

## Interface
- DATA_W, 128, width of din/rin/uin/dout
- ADDR_W, 8, width of addra/addrb
- LEN_W, 8, burst-length field width
- INST_W, 4+2*ADDR_W+LEN_W, instruction width; fields MSB→LSB: opcode[3:0], addra, addrb, len
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- inst  in  INST_W  instruction word
- inst_valid  in  1  inst is valid
- inst_ready  out  1  sequencer accepts inst this cycle
- axi_done  in  1  one-cycle pulse: current AXI beat finished
- din / rin / uin  in  DATA_W  AXI read data / accumulator read data / UB read data
- axi_sm_mode  out  2  00 idle, 01 load off-mem, 10 write off-mem
- axi_txn_en  out  1  AXI transaction request
- read_ub, write_ub, read_wb, write_wb, read_acc, write_acc  out  1 each  buffer strobes
- data_fifo_en, weight_fifo_en, mmu_load_weight_en, mm_en, acc_en  out  1 each  datapath strobes
- addra, addrb  out  ADDR_W  write / read address of current beat
- dout  out  DATA_W  write data
- busy  out  1  instruction in progress
- inst_done  out  1  one-cycle pulse on the last beat's final cycle
- err_illegal  out  1  sticky; set on an illegal opcode, cleared only by reset

## Operation
- Opcodes:
  - 0 NOP
  - 1 DATA_FIFO
  - 2 WEIGHT_FIFO
  - 3 AXI_TO_UB
  - 4 AXI_TO_WB
  - 5 UB_TO_DATA_FIFO
  - 6 UB_TO_WEIGHT_FIFO
  - 7 MAT_MUL
  - 8 MAT_MUL_ACC
  - 9 ACC_TO_UB
  - 10 UB_TO_AXI
  - 11–15 illegal: treated as NOP and set err_illegal
- Beat count = len+1 (len=0 → 1 beat). Both addresses increment by 1 per beat and wrap modulo 2^ADDR_W (0xFF→0x00 at ADDR_W=8).
- States and per-beat strobes:
  - IDLE
  - EXEC: one cycle per beat.
    - op1: data_fifo_en
    - op2: weight_fifo_en
    - op5: read_ub + data_fifo_en
    - op6: read_wb + weight_fifo_en + mmu_load_weight_en
    - op7: read_ub + data_fifo_en + mm_en + write_acc
    - op8: op7 strobes + acc_en
  - AXI_REQ (ops 3/4): axi_sm_mode=01, axi_txn_en=1 until axi_done is sampled. din is captured into din_q on the axi_done edge.
  - AXI_WR: write_ub (op3) or write_wb (op4) with dout=din_q.
  - ACC_RD: read_acc.
  - ACC_WR: write_ub with dout=rin.
  - UB_RD: read_ub.
  - UB_CAP: uin is captured into uin_q.
  - UB_AXI: axi_sm_mode=10, axi_txn_en=1, dout=uin_q, held until axi_done.
- Transitions:
  - IDLE→first state of the opcode on handshake. NOP or illegal: inst_done pulses in the cycle after acceptance; no strobes.
  - After the final state of each beat: next beat, or IDLE if it was the last beat.
- Outputs are a Moore decode of registered state. In IDLE and every unlisted case all strobes, axi_txn_en and axi_sm_mode are 0, and dout=0.
- inst_ready=1 only in IDLE; busy = !IDLE.

## Timing
- Reset: state IDLE; every output 0 except inst_ready=1. addra/addrb/dout/din_q/uin_q = 0; err_illegal=0.
- An instruction accepted at edge N issues its first beat's strobes in cycle N+1.
- EXEC bursts: strobes are continuous for len+1 cycles, then one IDLE cycle. Throughput is len+2 cycles per instruction.
- RAM read latency is 1: uin/rin are valid in the cycle after read_ub/read_acc.
- axi_done arriving in the first cycle of AXI_REQ/UB_AXI is legal and completes the beat. axi_txn_en drops in the following cycle and stays low at least one cycle between beats.
- axi_done outside AXI_REQ/UB_AXI is ignored.
- inst_valid while busy is held off; inst is not sampled.
- Reset mid-burst returns immediately to the reset values; the remaining beats are discarded.

## Test plan
- Reset, then DATA_FIFO len=3 addra=0x10 → data_fifo_en high 4 consecutive cycles; addra 0x10..0x13; inst_done on the 4th; inst_ready high on the next cycle.
- MAT_MUL_ACC len=1 addrb=0xFF → two beats with mm_en/acc_en/write_acc/read_ub; addrb 0xFF then 0x00 (wrap).
- AXI_TO_UB len=1, axi_done after 3 and then 0 extra cycles, din=0xA5…A5 then 0x5A…5A → write_ub one cycle per beat, dout equals the captured din, axi_txn_en low one cycle between beats.
- ACC_TO_UB len=0 with rin=0x1234 → read_acc for 1 cycle, then write_ub with dout=0x1234, then inst_done.
- UB_TO_AXI len=0 with uin=0xDEAD the cycle after read_ub → axi_sm_mode=10, dout=0xDEAD held until axi_done.
- Opcode 0xC → err_illegal=1 sticky, no strobes; then reset_n low mid-way through an AXI_TO_WB beat → all outputs 0 asynchronously, err_illegal cleared.

Source files
------------

// File: rtl/tpu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// tpu_seq_ctrl : burst instruction sequencer for the systolic-array TPU
// Rev 1.0
// ============================================================================
module tpu_seq_ctrl #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8,
  parameter int INST_W = 4 + 2*ADDR_W + LEN_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [INST_W-1:0] inst,
  input  logic              inst_valid,
  output logic              inst_ready,
  input  logic              axi_done,
  input  logic [DATA_W-1:0] din,
  input  logic [DATA_W-1:0] rin,
  input  logic [DATA_W-1:0] uin,
  output logic [1:0]        axi_sm_mode,
  output logic              axi_txn_en,
  output logic              read_ub,
  output logic              write_ub,
  output logic              read_wb,
  output logic              write_wb,
  output logic              read_acc,
  output logic              write_acc,
  output logic              data_fifo_en,
  output logic              weight_fifo_en,
  output logic              mmu_load_weight_en,
  output logic              mm_en,
  output logic              acc_en,
  output logic [ADDR_W-1:0] addra,
  output logic [ADDR_W-1:0] addrb,
  output logic [DATA_W-1:0] dout,
  output logic              busy,
  output logic              inst_done,
  output logic              err_illegal
);

  localparam logic [3:0] c_op_data_fifo   = 4'd1;
  localparam logic [3:0] c_op_weight_fifo = 4'd2;
  localparam logic [3:0] c_op_axi_to_ub   = 4'd3;
  localparam logic [3:0] c_op_axi_to_wb   = 4'd4;
  localparam logic [3:0] c_op_ub_to_df    = 4'd5;
  localparam logic [3:0] c_op_ub_to_wf    = 4'd6;
  localparam logic [3:0] c_op_mat_mul     = 4'd7;
  localparam logic [3:0] c_op_mat_mul_acc = 4'd8;
  localparam logic [3:0] c_op_acc_to_ub   = 4'd9;
  localparam logic [3:0] c_op_ub_to_axi   = 4'd10;

  typedef enum logic [3:0] {
    S_IDLE, S_NOP, S_EXEC, S_AXI_REQ, S_AXI_WR,
    S_ACC_RD, S_ACC_WR, S_UB_RD, S_UB_CAP, S_UB_AXI
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [3:0]          r_op;
  logic [LEN_W-1:0]    r_cnt;
  logic [ADDR_W-1:0]   r_addra, r_addrb;
  logic [DATA_W-1:0]   r_din_q, r_uin_q;
  logic                r_err;

  logic [3:0]          w_op;
  logic [ADDR_W-1:0]   w_addra, w_addrb;
  logic [LEN_W-1:0]    w_len;
  logic                w_accept, w_last, w_beat_end;

  assign w_op    = inst[INST_W-1 -: 4];
  assign w_addra = inst[INST_W-5 -: ADDR_W];
  assign w_addrb = inst[LEN_W+ADDR_W-1 -: ADDR_W];
  assign w_len   = inst[LEN_W-1:0];

  assign w_accept   = inst_valid && (r_state == S_IDLE);
  assign w_last     = (r_cnt == '0);
  assign w_beat_end = (r_state == S_EXEC) || (r_state == S_AXI_WR) ||
                      (r_state == S_ACC_WR) || ((r_state == S_UB_AXI) && axi_done);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (w_op)
            c_op_data_fifo, c_op_weight_fifo, c_op_ub_to_df,
            c_op_ub_to_wf, c_op_mat_mul, c_op_mat_mul_acc: w_state_nxt = S_EXEC;
            c_op_axi_to_ub, c_op_axi_to_wb:                w_state_nxt = S_AXI_REQ;
            c_op_acc_to_ub:                                w_state_nxt = S_ACC_RD;
            c_op_ub_to_axi:                                w_state_nxt = S_UB_RD;
            default:                                       w_state_nxt = S_NOP;
          endcase
        end
      end
      S_NOP:     w_state_nxt = S_IDLE;
      S_EXEC:    w_state_nxt = w_last ? S_IDLE : S_EXEC;
      S_AXI_REQ: w_state_nxt = axi_done ? S_AXI_WR : S_AXI_REQ;
      S_AXI_WR:  w_state_nxt = w_last ? S_IDLE : S_AXI_REQ;
      S_ACC_RD:  w_state_nxt = S_ACC_WR;
      S_ACC_WR:  w_state_nxt = w_last ? S_IDLE : S_ACC_RD;
      S_UB_RD:   w_state_nxt = S_UB_CAP;
      S_UB_CAP:  w_state_nxt = S_UB_AXI;
      S_UB_AXI:  if (axi_done) w_state_nxt = w_last ? S_IDLE : S_UB_RD;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_cnt   <= '0;
      r_addra <= '0;
      r_addrb <= '0;
      r_din_q <= '0;
      r_uin_q <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op    <= w_op;
        r_cnt   <= w_len;
        r_addra <= w_addra;
        r_addrb <= w_addrb;
        if (w_op > c_op_ub_to_axi) r_err <= 1'b1;
      end else if (w_beat_end) begin
        if (!w_last) r_cnt <= r_cnt - LEN_W'(1);
        r_addra <= r_addra + ADDR_W'(1);
        r_addrb <= r_addrb + ADDR_W'(1);
      end
      if ((r_state == S_AXI_REQ) && axi_done) r_din_q <= din;
      // uin answers the read_ub issued in the previous (UB_RD) cycle
      if (r_state == S_UB_CAP) r_uin_q <= uin;
    end
  end

  always_comb begin
    axi_sm_mode        = 2'b00;
    axi_txn_en         = 1'b0;
    read_ub            = 1'b0;
    write_ub           = 1'b0;
    read_wb            = 1'b0;
    write_wb           = 1'b0;
    read_acc           = 1'b0;
    write_acc          = 1'b0;
    data_fifo_en       = 1'b0;
    weight_fifo_en     = 1'b0;
    mmu_load_weight_en = 1'b0;
    mm_en              = 1'b0;
    acc_en             = 1'b0;
    dout               = '0;
    case (r_state)
      S_EXEC: begin
        case (r_op)
          c_op_data_fifo:   data_fifo_en = 1'b1;
          c_op_weight_fifo: weight_fifo_en = 1'b1;
          c_op_ub_to_df: begin
            read_ub      = 1'b1;
            data_fifo_en = 1'b1;
          end
          c_op_ub_to_wf: begin
            read_wb            = 1'b1;
            weight_fifo_en     = 1'b1;
            mmu_load_weight_en = 1'b1;
          end
          c_op_mat_mul, c_op_mat_mul_acc: begin
            read_ub      = 1'b1;
            data_fifo_en = 1'b1;
            mm_en        = 1'b1;
            write_acc    = 1'b1;
            acc_en       = (r_op == c_op_mat_mul_acc);
          end
          default: ;
        endcase
      end
      S_AXI_REQ: begin
        axi_sm_mode = 2'b01;
        axi_txn_en  = 1'b1;
      end
      S_AXI_WR: begin
        write_ub = (r_op == c_op_axi_to_ub);
        write_wb = (r_op == c_op_axi_to_wb);
        dout     = r_din_q;
      end
      S_ACC_RD: read_acc = 1'b1;
      S_ACC_WR: begin
        write_ub = 1'b1;
        dout     = rin;
      end
      S_UB_RD: read_ub = 1'b1;
      S_UB_AXI: begin
        axi_sm_mode = 2'b10;
        axi_txn_en  = 1'b1;
        dout        = r_uin_q;
      end
      default: ;
    endcase
  end

  assign addra       = r_addra;
  assign addrb       = r_addrb;
  assign inst_ready  = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign inst_done   = (r_state == S_NOP) || (w_beat_end && w_last);
  assign err_illegal = r_err;

endmodule
`default_nettype wire

// File: tb/tb_tpu_seq_ctrl.sv
`default_nettype none
// Bench for tpu_seq_ctrl: per-cycle expected trace built from the opcode rules,
// replayed against the DUT with random data, delays and ignored inputs.
module tb_tpu_seq_ctrl;
  localparam int DW = 128;
  localparam int AW = 8;
  localparam int LW = 8;
  localparam int IW = 4 + 2*AW + LW;

  localparam int RUB = 10, WUB = 9, RWB = 8, WWB = 7, RACC = 6, WACC = 5;
  localparam int DFE = 4, WFE = 3, MLW = 2, MM = 1, ACC = 0;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [IW-1:0] inst = '0;
  logic inst_valid = 1'b0, axi_done = 1'b0;
  logic [DW-1:0] din = '0, rin = '0, uin = '0;
  logic inst_ready, axi_txn_en, busy, inst_done, err_illegal;
  logic [1:0] axi_sm_mode;
  logic read_ub, write_ub, read_wb, write_wb, read_acc, write_acc;
  logic data_fifo_en, weight_fifo_en, mmu_load_weight_en, mm_en, acc_en;
  logic [AW-1:0] addra, addrb;
  logic [DW-1:0] dout;

  tpu_seq_ctrl dut (
    .clk(clk), .reset_n(reset_n), .inst(inst), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .axi_done(axi_done), .din(din), .rin(rin), .uin(uin),
    .axi_sm_mode(axi_sm_mode), .axi_txn_en(axi_txn_en),
    .read_ub(read_ub), .write_ub(write_ub), .read_wb(read_wb), .write_wb(write_wb),
    .read_acc(read_acc), .write_acc(write_acc), .data_fifo_en(data_fifo_en),
    .weight_fifo_en(weight_fifo_en), .mmu_load_weight_en(mmu_load_weight_en),
    .mm_en(mm_en), .acc_en(acc_en), .addra(addra), .addrb(addrb), .dout(dout),
    .busy(busy), .inst_done(inst_done), .err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [95:0]   tag;
    logic          valid;
    logic [IW-1:0] inst;
    logic          axi_done;
    logic [DW-1:0] din, rin, uin;
    logic [10:0]   stb;
    logic [1:0]    mode;
    logic          txn, ready, busy, done, err, chk;
    logic [AW-1:0] a, b;
    logic [DW-1:0] dout;
  } rec_t;

  rec_t q[$];
  logic err_m = 1'b0;
  int total = 0;
  int bad = 0;

  localparam int VW = 11 + 2 + 5 + 2*AW + DW;
  localparam logic [VW-1:0] RESET_VEC = {11'b0, 2'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, {DW{1'b0}}};

  function automatic logic [DW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [VW-1:0] obs();
    return {read_ub, write_ub, read_wb, write_wb, read_acc, write_acc, data_fifo_en,
            weight_fifo_en, mmu_load_weight_en, mm_en, acc_en, axi_sm_mode, axi_txn_en,
            inst_ready, busy, inst_done, err_illegal, addra, addrb, dout};
  endfunction

  function automatic logic [VW-1:0] exp_vec(input rec_t r);
    return {r.stb, r.mode, r.txn, r.ready, r.busy, r.done, r.err, r.a, r.b, r.dout};
  endfunction

  function automatic logic [VW-1:0] mask_of(input rec_t r);
    logic [VW-1:0] m;
    m = '1;
    if (!r.chk) m[DW +: 2*AW] = '0;
    return m;
  endfunction

  // Default cycle: busy, no strobes, random don't-care inputs (held-off inst, stray axi_done)
  function automatic rec_t blank(input logic [95:0] tag);
    rec_t r;
    r.tag = tag; r.valid = 1'($urandom_range(0, 1)); r.inst = IW'($urandom);
    r.axi_done = 1'($urandom_range(0, 1));
    r.din = rnd128(); r.rin = rnd128(); r.uin = rnd128();
    r.stb = '0; r.mode = '0; r.txn = 1'b0; r.ready = 1'b0; r.busy = 1'b1;
    r.done = 1'b0; r.err = err_m; r.chk = 1'b0; r.a = '0; r.b = '0; r.dout = '0;
    return r;
  endfunction

  function automatic rec_t idle_rec(input logic [95:0] tag);
    rec_t r;
    r = blank(tag);
    r.valid = 1'b0; r.busy = 1'b0; r.ready = 1'b1;
    return r;
  endfunction

  function automatic rec_t beat(input logic [95:0] tag, input logic [AW-1:0] a, b);
    rec_t r;
    r = blank(tag);
    r.chk = 1'b1; r.a = a; r.b = b;
    return r;
  endfunction

  function automatic logic [10:0] stb_of(input logic [3:0] op);
    logic [10:0] s;
    s = '0;
    case (op)
      4'd1: s[DFE] = 1'b1;
      4'd2: s[WFE] = 1'b1;
      4'd5: begin s[RUB] = 1'b1; s[DFE] = 1'b1; end
      4'd6: begin s[RWB] = 1'b1; s[WFE] = 1'b1; s[MLW] = 1'b1; end
      4'd7, 4'd8: begin
        s[RUB] = 1'b1; s[DFE] = 1'b1; s[MM] = 1'b1; s[WACC] = 1'b1;
        s[ACC] = (op == 4'd8);
      end
      default: ;
    endcase
    return s;
  endfunction

  // Appends the expected cycle trace of one instruction, starting with its issue cycle
  task automatic gen_inst(input logic [3:0] op, input logic [7:0] a, b, len,
                          input int dly0, dly1, input logic [DW-1:0] d0, d1,
                          input bit fix_d, input logic [95:0] tag);
    rec_t r;
    int d;
    logic [DW-1:0] v;
    logic [AW-1:0] ca, cb;
    logic last;
    r = idle_rec(tag);
    r.valid = 1'b1; r.inst = {op, a, b, len};
    q.push_back(r);
    if (op > 4'd10) err_m = 1'b1;
    if (op == 4'd0 || op > 4'd10) begin
      r = blank(tag); r.done = 1'b1; q.push_back(r);
      return;
    end
    for (int i = 0; i <= int'(len); i++) begin
      ca = a + AW'(i);
      cb = b + AW'(i);
      last = (i == int'(len));
      v = fix_d ? ((i == 0) ? d0 : d1) : rnd128();
      d = (i == 0) ? dly0 : dly1;
      if (d < 0) d = $urandom_range(0, 3);
      case (op)
        4'd3, 4'd4: begin
          for (int k = 0; k <= d; k++) begin
            r = beat(tag, ca, cb); r.mode = 2'b01; r.txn = 1'b1;
            r.axi_done = (k == d);
            if (k == d) r.din = v;
            q.push_back(r);
          end
          r = beat(tag, ca, cb);
          if (op == 4'd3) r.stb[WUB] = 1'b1; else r.stb[WWB] = 1'b1;
          r.dout = v; r.done = last; q.push_back(r);
        end
        4'd9: begin
          r = beat(tag, ca, cb); r.stb[RACC] = 1'b1; q.push_back(r);
          r = beat(tag, ca, cb); r.stb[WUB] = 1'b1; r.rin = v; r.dout = v;
          r.done = last; q.push_back(r);
        end
        4'd10: begin
          r = beat(tag, ca, cb); r.stb[RUB] = 1'b1; q.push_back(r);
          r = beat(tag, ca, cb); r.uin = v; q.push_back(r);
          for (int k = 0; k <= d; k++) begin
            r = beat(tag, ca, cb); r.mode = 2'b10; r.txn = 1'b1; r.dout = v;
            r.axi_done = (k == d); r.done = last && (k == d);
            q.push_back(r);
          end
        end
        default: begin
          r = beat(tag, ca, cb); r.stb = stb_of(op); r.done = last; q.push_back(r);
        end
      endcase
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (obs() !== RESET_VEC) begin
      bad++; $display("FAIL reset_held got=%h exp=%h", obs(), RESET_VEC);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    total++;
    if (obs() !== RESET_VEC) begin
      bad++; $display("FAIL reset_release got=%h exp=%h", obs(), RESET_VEC);
    end
  endtask

  task automatic test_directed();
    logic [VW-1:0] e, m;
    gen_inst(4'd1, 8'h10, 8'h40, 8'd3, 0, 0, '0, '0, 1'b0, "data_fifo");
    gen_inst(4'd8, 8'h05, 8'hFF, 8'd1, 0, 0, '0, '0, 1'b0, "mm_acc_wrap");
    gen_inst(4'd3, 8'h80, 8'h90, 8'd1, 3, 0, {16{8'hA5}}, {16{8'h5A}}, 1'b1, "axi_to_ub");
    gen_inst(4'd9, 8'h21, 8'h31, 8'd0, 0, 0, DW'(16'h1234), '0, 1'b1, "acc_to_ub");
    gen_inst(4'd10, 8'h44, 8'h55, 8'd0, 2, 2, DW'(16'hDEAD), '0, 1'b1, "ub_to_axi");
    gen_inst(4'd0, 8'h01, 8'h02, 8'd7, 0, 0, '0, '0, 1'b0, "nop");
    gen_inst(4'hC, 8'h03, 8'h04, 8'd2, 0, 0, '0, '0, 1'b0, "illegal");
    gen_inst(4'd6, 8'hFE, 8'h7F, 8'd2, 0, 0, '0, '0, 1'b0, "err_sticky");
    q.push_back(idle_rec("tail"));
    foreach (q[i]) begin
      @(negedge clk);
      inst_valid = q[i].valid; inst = q[i].inst; axi_done = q[i].axi_done;
      din = q[i].din; rin = q[i].rin; uin = q[i].uin;
      #1;
      e = exp_vec(q[i]); m = mask_of(q[i]);
      total++;
      if ((obs() & m) !== (e & m)) begin
        bad++; $display("FAIL %0s cyc=%0d got=%h exp=%h", q[i].tag, i, obs() & m, e & m);
      end
    end
    q.delete();
  endtask

  task automatic test_back_to_back();
    logic [VW-1:0] e, m;
    logic [7:0] a, b;
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 2)) q.push_back(idle_rec("gap"));
      a = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(250, 255)) : 8'($urandom);
      b = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(250, 255)) : 8'($urandom);
      gen_inst(4'($urandom_range(0, 15)), a, b, 8'($urandom_range(0, 5)), -1, -1,
               '0, '0, 1'b0, "random");
    end
    q.push_back(idle_rec("tail"));
    foreach (q[i]) begin
      @(negedge clk);
      inst_valid = q[i].valid; inst = q[i].inst; axi_done = q[i].axi_done;
      din = q[i].din; rin = q[i].rin; uin = q[i].uin;
      #1;
      e = exp_vec(q[i]); m = mask_of(q[i]);
      total++;
      if ((obs() & m) !== (e & m)) begin
        bad++; $display("FAIL %0s cyc=%0d got=%h exp=%h", q[i].tag, i, obs() & m, e & m);
      end
    end
    q.delete();
  endtask

  task automatic test_reset_mid_burst();
    logic [VW-1:0] e, m;
    if (!err_m) gen_inst(4'hF, 8'h00, 8'h00, 8'd0, 0, 0, '0, '0, 1'b0, "set_err");
    gen_inst(4'd4, 8'h20, 8'h30, 8'd3, 6, 6, '0, '0, 1'b0, "axi_to_wb");
    // stop partway through the first beat's AXI wait
    while (q.size() > 0 && !(q[0].tag == "axi_to_wb" && q[0].txn && q[0].b == 8'h30 && q[1].txn && !q[2].txn)) begin
      @(negedge clk);
      inst_valid = q[0].valid; inst = q[0].inst; axi_done = q[0].axi_done;
      din = q[0].din; rin = q[0].rin; uin = q[0].uin;
      #1;
      e = exp_vec(q[0]); m = mask_of(q[0]);
      total++;
      if ((obs() & m) !== (e & m)) begin
        bad++; $display("FAIL %0s got=%h exp=%h", q[0].tag, obs() & m, e & m);
      end
      void'(q.pop_front());
    end
    q.delete();
    @(negedge clk);
    inst_valid = 1'b0; axi_done = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    err_m = 1'b0;
    total++;
    if (obs() !== RESET_VEC) begin
      bad++; $display("FAIL reset_mid_burst got=%h exp=%h", obs(), RESET_VEC);
    end
    @(negedge clk);
    reset_n = 1'b1;
    q.push_back(idle_rec("post_reset"));
    gen_inst(4'd2, 8'hFF, 8'h00, 8'd1, 0, 0, '0, '0, 1'b0, "post_reset");
    q.push_back(idle_rec("post_reset"));
    q.push_back(idle_rec("post_reset"));
    foreach (q[i]) begin
      @(negedge clk);
      inst_valid = q[i].valid; inst = q[i].inst; axi_done = q[i].axi_done;
      din = q[i].din; rin = q[i].rin; uin = q[i].uin;
      #1;
      e = exp_vec(q[i]); m = mask_of(q[i]);
      total++;
      if ((obs() & m) !== (e & m)) begin
        bad++; $display("FAIL %0s cyc=%0d got=%h exp=%h", q[i].tag, i, obs() & m, e & m);
      end
    end
    q.delete();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
